// File: rtl/cache_mem_scheduler.sv
// Arbiter that lets an icache and a dcache share one cacheline memory port.
// Dcache wins contested cycles until icache has lost STARVE_LIMIT contests in
// a row; then icache is forced through. Each transaction is latched at grant,
// held until memory responds, then followed by one RECOVER cycle that absorbs
// the requester's still-high strobe.
module cache_mem_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic [31:0]  i_address,
    input  logic         i_read,
    input  logic         i_write,
    input  logic [255:0] i_wdata,
    output logic [255:0] i_rdata,
    output logic         i_resp,

    input  logic [31:0]  d_address,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,

    output logic [31:0]  m_address,
    output logic         m_read,
    output logic         m_write,
    output logic [255:0] m_wdata,
    input  logic [255:0] m_rdata,
    input  logic         m_resp
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE_C = STARVE_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t               state_r;
    logic [STARVE_W-1:0]  starve_cnt_r;
    logic [31:0]          lat_addr_r;
    logic [255:0]         lat_wdata_r;
    logic                 m_read_r;
    logic                 m_write_r;

    logic                 i_req_s;
    logic                 d_req_s;
    logic                 pick_i_s;
    logic                 pick_d_s;
    logic                 starved_s;
    logic                 i_resp_s;
    logic                 d_resp_s;

    // Arbitration: a lone requester wins; on contention dcache wins unless icache is starved.
    always_comb begin
        i_req_s   = i_read | i_write;
        d_req_s   = d_read | d_write;
        starved_s = (starve_cnt_r == STARVE_MAX_C);
        pick_i_s  = 1'b0;
        pick_d_s  = 1'b0;
        if (i_req_s && d_req_s) begin
            if (starved_s) begin
                pick_i_s = 1'b1;
            end else begin
                pick_d_s = 1'b1;
            end
        end else if (i_req_s) begin
            pick_i_s = 1'b1;
        end else if (d_req_s) begin
            pick_d_s = 1'b1;
        end else begin
            pick_i_s = 1'b0;
            pick_d_s = 1'b0;
        end
    end

    // Completion: memory's response is forwarded only to the port currently granted.
    always_comb begin
        i_resp_s = 1'b0;
        d_resp_s = 1'b0;
        if (m_resp && (state_r == GRANT_I)) begin
            i_resp_s = 1'b1;
        end else if (m_resp && (state_r == GRANT_D)) begin
            d_resp_s = 1'b1;
        end else begin
            i_resp_s = 1'b0;
            d_resp_s = 1'b0;
        end
    end

    // Scheduler FSM: grant, latch the request, hold memory strobes until m_resp, recover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            starve_cnt_r <= {STARVE_W{1'b0}};
            lat_addr_r   <= 32'h0000_0000;
            lat_wdata_r  <= {256{1'b0}};
            m_read_r     <= 1'b0;
            m_write_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_i_s) begin
                        state_r      <= GRANT_I;
                        lat_addr_r   <= i_address;
                        lat_wdata_r  <= i_wdata;
                        m_read_r     <= ~i_write;
                        m_write_r    <= i_write;
                        starve_cnt_r <= {STARVE_W{1'b0}};
                    end else if (pick_d_s) begin
                        state_r     <= GRANT_D;
                        lat_addr_r  <= d_address;
                        lat_wdata_r <= d_wdata;
                        m_read_r    <= ~d_write;
                        m_write_r   <= d_write;
                        if (i_req_s && !starved_s) begin
                            starve_cnt_r <= starve_cnt_r + STARVE_ONE_C;
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (m_resp) begin
                        state_r   <= RECOVER;
                        m_read_r  <= 1'b0;
                        m_write_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RECOVER: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    m_read_r  <= 1'b0;
                    m_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign m_address = lat_addr_r;
    assign m_wdata   = lat_wdata_r;
    assign m_read    = m_read_r;
    assign m_write   = m_write_r;
    assign i_resp    = i_resp_s;
    assign d_resp    = d_resp_s;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_cache_mem_scheduler.sv
// Directed bench for cache_mem_scheduler: expected grants are queued as
// requests are driven and compared when the memory strobes appear.
module tb_cache_mem_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_address, d_address, m_address;
    logic         i_read, i_write, d_read, d_write;
    logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;
    logic         i_resp, d_resp, m_read, m_write, m_resp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } grant_t;

    grant_t exp_q[$];

    cache_mem_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata);
        grant_t g;
        g.is_d = is_d; g.wr = wr; g.addr = addr; g.wdata = wdata;
        exp_q.push_back(g);
    endtask

    // Wait for a grant, compare against the scoreboard, serve it after lat cycles.
    task automatic transact(input string tag, input int max_wait, input int lat,
                            input logic [255:0] rd, input bit drop);
        grant_t e;
        bit seen = 1'b0;
        for (int c = 0; c < max_wait && !seen; c++) begin
            tick();
            if (m_read || m_write) seen = 1'b1;
        end
        check({tag, " grant_seen"}, 256'(seen), 256'(1'b1));
        if (!seen) return;
        check({tag, " queue_nonempty"}, 256'(exp_q.size() > 0), 256'(1'b1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, " m_address"}, 256'(m_address), 256'(e.addr));
        check({tag, " m_read"}, 256'(m_read), 256'(!e.wr));
        check({tag, " m_write"}, 256'(m_write), 256'(e.wr));
        if (e.wr) check({tag, " m_wdata"}, m_wdata, e.wdata);
        if (drop) begin
            i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
        for (int k = 1; k < lat; k++) begin
            tick();
            check({tag, " hold_strobe"}, 256'({m_read, m_write}), 256'({!e.wr, e.wr}));
            check({tag, " hold_addr"}, 256'(m_address), 256'(e.addr));
            check({tag, " early_resp"}, 256'({i_resp, d_resp}), 256'(2'b00));
        end
        m_rdata = rd;
        m_resp  = 1'b1;
        #1;
        check({tag, " i_resp"}, 256'(i_resp), 256'(!e.is_d));
        check({tag, " d_resp"}, 256'(d_resp), 256'(e.is_d));
        check({tag, " rdata"}, e.is_d ? d_rdata : i_rdata, rd);
        tick();
        m_resp = 1'b0;
        #1;
        check({tag, " recover_strobes"}, 256'({m_read, m_write}), 256'(2'b00));
        check({tag, " recover_resp"}, 256'({i_resp, d_resp}), 256'(2'b00));
    endtask

    initial begin
        rst = 1'b1;
        i_address = 32'h0; i_read = 1'b0; i_write = 1'b0; i_wdata = 256'h0;
        d_address = 32'h0; d_read = 1'b0; d_write = 1'b0; d_wdata = 256'h0;
        m_rdata = 256'h0; m_resp = 1'b0;
        tick();
        tick();
        check("reset_strobes", 256'({m_read, m_write}), 256'(2'b00));
        check("reset_resp", 256'({i_resp, d_resp}), 256'(2'b00));
        check("reset_addr", 256'(m_address), 256'(32'h0));
        check("reset_wdata", m_wdata, 256'h0);
        rst = 1'b0;

        // Lone icache read, memory answers three cycles after m_read.
        i_address = 32'h0000_1000; i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_1000, 256'h0);
        transact("icache_read", 4, 3, {8{32'hCAFE_0001}}, 1'b0);
        i_read = 1'b0;

        // Simultaneous icache read and dcache write: dcache first, icache after RECOVER.
        tick(); tick();
        i_address = 32'h0000_2000; i_read = 1'b1;
        d_address = 32'h8000_0040; d_write = 1'b1; d_wdata = {32{8'hA5}};
        push(1'b1, 1'b1, 32'h8000_0040, {32{8'hA5}});
        push(1'b0, 1'b0, 32'h0000_2000, 256'h0);
        transact("contest_d", 4, 2, 256'h0, 1'b0);
        d_write = 1'b0;
        transact("contest_i", 8, 2, {8{32'h1234_5678}}, 1'b0);
        i_read = 1'b0;

        // Continuous contention: icache forced in after four dcache wins.
        tick(); tick();
        i_address = 32'h0000_3000; i_read = 1'b1;
        d_address = 32'h0000_4000; d_read = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n == 4 || n == 9) push(1'b0, 1'b0, 32'h0000_3000, 256'h0);
            else push(1'b1, 1'b0, 32'h0000_4000, 256'h0);
        end
        for (int n = 0; n < 10; n++) begin
            transact($sformatf("starve_%0d", n), 8, 1, 256'(n + 100), 1'b0);
        end
        i_read = 1'b0; d_read = 1'b0;

        // Read+write together counts as write; strobe dropped mid-grant is ignored.
        tick(); tick();
        i_address = 32'h0000_5000; i_read = 1'b1; i_write = 1'b1; i_wdata = {16{16'hBEEF}};
        push(1'b0, 1'b1, 32'h0000_5000, {16{16'hBEEF}});
        transact("rw_write_drop", 4, 3, 256'h0, 1'b1);

        // Reset during a dcache write abandons it; pending icache read granted first edge after.
        tick(); tick();
        d_address = 32'h0000_6000; d_write = 1'b1; d_wdata = {8{32'h0BAD_F00D}};
        i_address = 32'h0000_7000; i_read = 1'b1;
        tick();
        check("pre_rst_m_write", 256'(m_write), 256'(1'b1));
        check("pre_rst_addr", 256'(m_address), 256'(32'h0000_6000));
        #2;
        rst = 1'b1;
        m_resp = 1'b1;
        #1;
        check("rst_async_strobes", 256'({m_read, m_write}), 256'(2'b00));
        check("rst_no_resp", 256'({i_resp, d_resp}), 256'(2'b00));
        d_write = 1'b0;
        m_resp = 1'b0;
        tick();
        rst = 1'b0;
        push(1'b0, 1'b0, 32'h0000_7000, 256'h0);
        transact("post_rst_i", 1, 2, {8{32'h5A5A_0000}}, 1'b0);
        i_read = 1'b0;

        // Stray m_resp in IDLE, then a strobe held through RECOVER must not re-issue.
        tick(); tick();
        m_resp = 1'b1;
        #1;
        check("idle_mresp_resp", 256'({i_resp, d_resp}), 256'(2'b00));
        tick();
        m_resp = 1'b0;
        check("idle_mresp_strobes", 256'({m_read, m_write}), 256'(2'b00));
        i_address = 32'h0000_8000; i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_8000, 256'h0);
        transact("idle_then_grant", 1, 2, {8{32'h7777_0000}}, 1'b0);
        tick();
        i_read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_reissue", 256'({m_read, m_write}), 256'(2'b00));
        end

        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
